tt_um_priority_decoder: RTL and testbench

Sequential one-hot decoder, the receive-side partner of the 16-bit priority encoder. It accepts an 8-bit position code (0x00–0x0F for bit position, 0xF0 for "no bit set") and rebuilds the 16-bit one-hot pattern, either replacing or OR-accumulating into an internal mask. The 16-bit result is serialized over the 8-bit output bus, high byte first, with a ready/valid handshake. It sits on the Tiny Tapeout user-project pin set, next to the encoder.

---
 rtl/tt_um_priority_decoder_if.sv | 22 ++
 rtl/tt_um_priority_decoder.sv | 115 +++++++++++
 tb/tb_tt_um_priority_decoder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tt_um_priority_decoder_if.sv
// Pin bundle of the priority decoder: enable, position code, control
// inputs, serialized mask byte, status/handshake bits and pad enables.
interface tt_um_priority_decoder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Producer side: drives code and controls, observes the mask bytes.
    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    // Decoder side.
    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_priority_decoder.sv
// Sequential one-hot decoder: takes an 8-bit position code, rebuilds the
// 16-bit one-hot pattern into a replace/accumulate mask and sends the mask
// out high byte first, one code every four cycles.
module tt_um_priority_decoder (
    input  logic                           clk,
    input  logic                           rst_n,
    tt_um_priority_decoder_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, DECODE, SEND_HI, SEND_LO} state_t;

    state_t      state;
    logic [7:0]  code_q;
    logic        acc_q;
    logic [15:0] mask;
    logic [7:0]  out_byte;
    logic        in_ready;
    logic        out_valid;
    logic        phase;
    logic        none_q;
    logic        err_q;

    logic        in_valid;
    logic        acc_in;
    logic        clear_in;
    logic        unused_inputs;

    logic        is_pos;
    logic        is_none;
    logic        is_err;
    logic [15:0] onehot;
    logic [15:0] next_mask;

    assign in_valid      = bus.uio_in[0];
    assign acc_in        = bus.uio_in[1];
    assign clear_in      = bus.uio_in[2];
    assign unused_inputs = &{1'b0, bus.uio_in[7:3]};

    // Classify the captured code and form the mask it produces.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // can leave one unassigned and turn it into a latch.
        is_pos    = (code_q[7:4] == 4'h0);
        is_none   = (code_q == 8'hF0);
        is_err    = !is_pos && !is_none;
        onehot    = 16'h0000;
        next_mask = mask;
        if (is_pos) begin
            onehot = 16'h0001 << code_q[3:0];
        end
        if (!is_err) begin
            next_mask = acc_q ? (mask | onehot) : onehot;
        end
    end

    // Control FSM with registered outputs; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            code_q    <= 8'h00;
            acc_q     <= 1'b0;
            mask      <= 16'h0000;
            out_byte  <= 8'h00;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            phase     <= 1'b0;
            none_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (bus.ena) begin
            // NOTE: non-blocking assignments make every register here update
            // from pre-edge values, so ordering inside the block is irrelevant.
            case (state)
                IDLE: begin
                    // Clear lands at the sampling edge; a code arriving with
                    // it is then decoded against the already-cleared mask.
                    if (clear_in) begin
                        mask <= 16'h0000;
                    end
                    if (in_valid) begin
                        code_q   <= bus.ui_in;
                        acc_q    <= acc_in;
                        in_ready <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    mask      <= next_mask;
                    out_byte  <= next_mask[15:8];
                    out_valid <= 1'b1;
                    phase     <= 1'b1;
                    none_q    <= is_none;
                    err_q     <= is_err;
                    state     <= SEND_HI;
                end
                SEND_HI: begin
                    out_byte <= mask[7:0];
                    phase    <= 1'b0;
                    state    <= SEND_LO;
                end
                SEND_LO: begin
                    out_byte  <= 8'h00;
                    out_valid <= 1'b0;
                    none_q    <= 1'b0;
                    err_q     <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.uo_out  = out_byte;
    assign bus.uio_out = {err_q, none_q, phase, out_valid, in_ready, 3'b000};
    assign bus.uio_oe  = 8'hF8;
endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// Bench for tt_um_priority_decoder: directed cases from the decoder's
// behaviour plus randomized codes, checked against a mask model.
module tb_tt_um_priority_decoder;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [15:0] model_mask;

    tt_um_priority_decoder_if bus ();

    tt_um_priority_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mask model: clear first, positions set bit (code), 0xF0 sets nothing,
    // anything else leaves the mask alone and flags an error.
    task automatic model_apply(input logic [7:0] code, input bit acc, input bit clr,
                               output bit exp_none, output bit exp_err);
        int oh;
        if (clr) model_mask = 16'h0000;
        exp_none = (code == 8'hF0);
        exp_err  = !exp_none && (code > 8'h0F);
        oh = (code <= 8'h0F) ? (1 << code) : 0;
        if (!exp_err) model_mask = acc ? (model_mask | oh[15:0]) : oh[15:0];
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 8 && bus.uio_out[3] !== 1'b1; i++) tick();
        check("ready_wait", {15'd0, bus.uio_out[3]}, 16'd1);
    endtask

    // One full transfer; optional ena stall in DECODE and in_valid pulse in SEND_HI.
    task automatic do_txn(input logic [7:0] code, input bit acc, input bit clr,
                          input int stall, input bit pulse, input string tag);
        bit en, ee;
        model_apply(code, acc, clr, en, ee);
        wait_ready();
        bus.ui_in  = code;
        bus.uio_in = {5'b0, clr, acc, 1'b1};
        tick();
        bus.uio_in = 8'h00;
        bus.ui_in  = 8'($urandom);
        check({tag, "_decode_ctl"}, bus.uio_out, 8'h00);
        if (stall > 0) begin
            bus.ena = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                check({tag, "_stall_ctl"}, bus.uio_out, 8'h00);
                check({tag, "_stall_byte"}, bus.uo_out, 8'h00);
            end
            bus.ena = 1'b1;
        end
        tick();
        check({tag, "_hi_byte"}, bus.uo_out, model_mask[15:8]);
        check({tag, "_hi_ctl"}, bus.uio_out, {ee, en, 1'b1, 1'b1, 1'b0, 3'b000});
        if (pulse) bus.uio_in = 8'h07;
        tick();
        bus.uio_in = 8'h00;
        check({tag, "_lo_byte"}, bus.uo_out, model_mask[7:0]);
        check({tag, "_lo_ctl"}, bus.uio_out, {ee, en, 1'b0, 1'b1, 1'b0, 3'b000});
        tick();
        check({tag, "_idle_ctl"}, bus.uio_out, 8'h08);
        check({tag, "_idle_byte"}, bus.uo_out, 8'h00);
        if (pulse) begin
            tick();
            check({tag, "_no_extra"}, bus.uio_out, 8'h08);
        end
    endtask

    initial begin
        bit en, ee;
        logic [7:0] rc;
        total      = 0;
        bad        = 0;
        model_mask = 16'h0000;
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        repeat (3) tick();
        check("rst_uo_out", bus.uo_out, 8'h00);
        check("rst_uio_out", bus.uio_out, 8'h08);
        check("rst_uio_oe", bus.uio_oe, 8'hF8);
        rst_n = 1'b1;
        tick();

        // Replace with the top position.
        do_txn(8'h0F, 1'b0, 1'b0, 0, 1'b0, "rep_0f");
        check("rep_0f_hi_literal", {8'h00, model_mask[15:8]}, 16'h0080);

        // Accumulate 3, 10, 3 starting from a cleared mask.
        do_txn(8'h03, 1'b0, 1'b0, 0, 1'b0, "acc_03a");
        do_txn(8'h0A, 1'b1, 1'b0, 0, 1'b0, "acc_0a");
        do_txn(8'h03, 1'b1, 1'b0, 0, 1'b0, "acc_03b");

        // Illegal code keeps the mask and raises err.
        do_txn(8'h25, 1'b1, 1'b0, 0, 1'b0, "illegal_25");

        // Clear alone: no transfer, mask cleared; then code 0 accumulates into 0.
        bus.uio_in = 8'h04;
        tick();
        bus.uio_in = 8'h00;
        model_mask = 16'h0000;
        check("clear_no_xfer", bus.uio_out, 8'h08);
        tick();
        check("clear_no_xfer2", bus.uio_out, 8'h08);
        do_txn(8'h00, 1'b1, 1'b0, 0, 1'b0, "after_clear_00");

        // None code in replace mode.
        do_txn(8'hF0, 1'b0, 1'b0, 0, 1'b0, "none_f0");

        // Fill the mask, then clear + valid with accumulate; pulse dropped in SEND_HI.
        for (int i = 0; i < 16; i++) do_txn(8'(i), 1'b1, 1'b0, 0, 1'b0, "fill");
        do_txn(8'h07, 1'b1, 1'b1, 0, 1'b1, "clr_valid_07");

        // Continuous in_valid: re-accepted at N+4.
        model_apply(8'h02, 1'b0, 1'b0, en, ee);
        bus.ui_in  = 8'h02;
        bus.uio_in = 8'h01;
        tick();
        check("b2b_decode1", bus.uio_out, 8'h00);
        tick();
        check("b2b_hi1", bus.uo_out, model_mask[15:8]);
        tick();
        check("b2b_lo1", bus.uo_out, model_mask[7:0]);
        tick();
        check("b2b_idle", bus.uio_out, 8'h08);
        tick();
        bus.uio_in = 8'h00;
        check("b2b_reaccept", bus.uio_out, 8'h00);
        tick();
        check("b2b_hi2_ctl", bus.uio_out, 8'h30);
        tick();
        check("b2b_lo2", bus.uo_out, model_mask[7:0]);
        tick();

        // Reset in SEND_HI abandons the transfer and clears the mask.
        model_apply(8'h05, 1'b0, 1'b0, en, ee);
        bus.ui_in  = 8'h05;
        bus.uio_in = 8'h01;
        tick();
        bus.uio_in = 8'h00;
        tick();
        check("pre_rst_hi_ctl", bus.uio_out, 8'h30);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_uo_out", bus.uo_out, 8'h00);
        check("midrst_uio_out", bus.uio_out, 8'h08);
        model_mask = 16'h0000;
        tick();
        rst_n = 1'b1;
        tick();
        do_txn(8'h08, 1'b1, 1'b0, 0, 1'b0, "post_rst_08");

        // ena low for three cycles while in DECODE.
        do_txn(8'h0C, 1'b1, 1'b0, 3, 1'b0, "ena_stall");

        // Randomized codes, modes and clears.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    rc = 8'($urandom_range(0, 15));
                2:       rc = 8'hF0;
                default: rc = 8'($urandom_range(0, 255));
            endcase
            do_txn(rc, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 0, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
